dadda_mac_acc: RTL and testbench



---
 rtl/dadda_pkg.sv | 24 ++
 rtl/dadda_mac_acc_if.sv | 40 ++++
 rtl/dadda_acc_add.sv | 43 ++++
 rtl/dadda_mac_acc.sv | 136 +++++++++++++
 tb/tb_dadda_mac_acc.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dadda_pkg.sv
// -----------------------------------------------------------------------------
// dadda_pkg
// Shared constants and types for the dadda_16 multiply-accumulate stage.
//   DADDA_PROD_W : width of a dadda_16 product (unsigned 16x16 -> 32)
//   DADDA_ACC_W  : default accumulator width
//   DADDA_CNT_W  : default width of the term-count field
//   prod_t       : one product word as produced by dadda_16
//   acc_state_e  : accumulator control states
// -----------------------------------------------------------------------------
package dadda_pkg;

    localparam int DADDA_PROD_W = 32;
    localparam int DADDA_ACC_W  = 40;
    localparam int DADDA_CNT_W  = 8;

    typedef logic [DADDA_PROD_W-1:0] prod_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_e;

endpackage : dadda_pkg

// File: rtl/dadda_mac_acc_if.sv
// -----------------------------------------------------------------------------
// dadda_mac_acc_if
// Bundles the control, product-stream and result-stream signals of the
// multiply-accumulate stage.
//   master : drives start/len, the product stream and acc_ready
//   slave  : the accumulator (accepts products, presents acc/acc_valid)
// Signals:
//   start, len                          - begin an accumulation of len terms
//   prod, prod_valid, prod_ready        - product stream (valid/ready)
//   acc, acc_valid, acc_ready, acc_ovf  - result stream (valid/ready) + carry flag
//   busy                                - accumulator not idle
// -----------------------------------------------------------------------------
interface dadda_mac_acc_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) ();

    logic              start;
    logic [CNT_W-1:0]  len;
    logic [PROD_W-1:0] prod;
    logic              prod_valid;
    logic              prod_ready;
    logic [ACC_W-1:0]  acc;
    logic              acc_valid;
    logic              acc_ready;
    logic              acc_ovf;
    logic              busy;

    modport master (
        output start, len, prod, prod_valid, acc_ready,
        input  prod_ready, acc, acc_valid, acc_ovf, busy
    );

    modport slave (
        input  start, len, prod, prod_valid, acc_ready,
        output prod_ready, acc, acc_valid, acc_ovf, busy
    );

endinterface : dadda_mac_acc_if

// File: rtl/dadda_acc_add.sv
// -----------------------------------------------------------------------------
// dadda_acc_add
// Combinational accumulator adder: i_acc + zero-extended i_prod, computed one
// bit wider than the accumulator so the top bit is the carry-out.
// Optional macro DADDA_ACC_SAT_EN: on carry the sum is clamped to all-ones
// instead of wrapping. Once clamped, any further nonzero term carries again,
// so the accumulator stays at full scale for the rest of the run.
// Ports:
//   i_acc   [ACC_W]  current accumulator value
//   i_prod  [PROD_W] unsigned product
//   o_sum   [ACC_W]  next accumulator value (wrapped or clamped)
//   o_carry [1]      carry-out of the ACC_W-bit add
// -----------------------------------------------------------------------------
module dadda_acc_add
    import dadda_pkg::*;
#(
    parameter int PROD_W = DADDA_PROD_W,
    parameter int ACC_W  = DADDA_ACC_W
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);

    logic [ACC_W:0] w_full;

    // Wide add with the product zero-extended to ACC_W+1 bits.
    always_comb begin
        w_full  = {1'b0, i_acc} + {{(ACC_W+1-PROD_W){1'b0}}, i_prod};
        o_carry = w_full[ACC_W];
`ifdef DADDA_ACC_SAT_EN
        if (w_full[ACC_W]) begin
            o_sum = {ACC_W{1'b1}};
        end else begin
            o_sum = w_full[ACC_W-1:0];
        end
`else
        o_sum = w_full[ACC_W-1:0];
`endif
    end

endmodule : dadda_acc_add

// File: rtl/dadda_mac_acc.sv
// -----------------------------------------------------------------------------
// dadda_mac_acc
// Accumulates a programmed number of unsigned dadda_16 products and presents
// the sum over a valid/ready handshake. Control is a three-state FSM
// (IDLE -> ACCUM -> DONE -> IDLE); len==0 skips straight to DONE with a zero
// sum. acc_ovf is sticky for the current accumulation and is cleared by start.
// Optional macro DADDA_ACC_SAT_EN (see dadda_acc_add): clamp instead of wrap.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts and discards a partial sum)
//   bus    dadda_mac_acc_if.slave: start/len, prod stream, acc stream, busy
// All outputs on bus are driven straight from registers.
// -----------------------------------------------------------------------------
module dadda_mac_acc
    import dadda_pkg::*;
#(
    parameter int PROD_W = DADDA_PROD_W,
    parameter int ACC_W  = DADDA_ACC_W,
    parameter int CNT_W  = DADDA_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    dadda_mac_acc_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    acc_state_e       r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_rem;
    logic             r_prod_ready;
    logic             r_acc_valid;
    logic             r_busy;

    acc_state_e       w_state_nxt;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;
    logic [CNT_W-1:0] w_rem_nxt;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;
    logic             w_take;

    dadda_acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .i_acc   (r_acc),
        .i_prod  (bus.prod),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // A product transfers only while ACCUM advertises ready.
    assign w_take = bus.prod_valid && r_prod_ready;

    // Next-state and datapath update; every path holds state unless told otherwise.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_rem_nxt   = r_rem;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_acc_nxt = {ACC_W{1'b0}};
                    w_ovf_nxt = 1'b0;
                    if (bus.len != CNT_ZERO) begin
                        w_state_nxt = ST_ACCUM;
                        w_rem_nxt   = bus.len;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_rem_nxt   = CNT_ZERO;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_take) begin
                    w_acc_nxt = w_sum;
                    w_ovf_nxt = r_ovf | w_carry;
                    w_rem_nxt = r_rem - CNT_ONE;
                    // Leaving on remaining==1 means the counter bottoms out at 0, never wraps.
                    if (r_rem == CNT_ONE) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (bus.acc_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output flags; flags are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_acc        <= {ACC_W{1'b0}};
            r_ovf        <= 1'b0;
            r_rem        <= CNT_ZERO;
            r_prod_ready <= 1'b0;
            r_acc_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_ovf        <= w_ovf_nxt;
            r_rem        <= w_rem_nxt;
            r_prod_ready <= (w_state_nxt == ST_ACCUM);
            r_acc_valid  <= (w_state_nxt == ST_DONE);
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.prod_ready = r_prod_ready;
    assign bus.acc        = r_acc;
    assign bus.acc_valid  = r_acc_valid;
    assign bus.acc_ovf    = r_ovf;
    assign bus.busy       = r_busy;

endmodule : dadda_mac_acc

// File: tb/tb_dadda_mac_acc.sv
// -----------------------------------------------------------------------------
// tb_dadda_mac_acc
// Self-checking bench for dadda_mac_acc. Instance A uses the default 40-bit
// accumulator; instance B uses a 33-bit accumulator to exercise the carry.
// Expected sums come from a plain-arithmetic model (64-bit sum of the term
// list, reduced to the accumulator width). Inputs change and outputs are
// sampled on the falling edge.
// Honours DADDA_ACC_SAT_EN when computing expectations.
// -----------------------------------------------------------------------------
module tb_dadda_mac_acc;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    logic [31:0] q_prod[$];

    dadda_mac_acc_if #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) ifa ();
    dadda_mac_acc_if #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) ifb ();

    dadda_mac_acc #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    dadda_mac_acc #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: true sum reduced to a w-bit accumulator.
    function automatic logic [63:0] model_acc(input logic [63:0] s, input int w);
        logic [63:0] lim;
        lim = (64'd1 << w) - 64'd1;
`ifdef DADDA_ACC_SAT_EN
        if (s > lim) return lim;
`endif
        return s & lim;
    endfunction

    function automatic logic [63:0] model_ovf(input logic [63:0] s, input int w);
        return ((s >> w) != 64'd0) ? 64'd1 : 64'd0;
    endfunction

    // One full accumulation on instance A using the terms in q_prod.
    task automatic run_a(input int gap_max, input int rdy_delay, input bit start_on_exit);
        logic [63:0] s;
        logic [63:0] e_acc;
        logic [63:0] e_ovf;
        int n;
        n = q_prod.size();
        s = 64'd0;
        foreach (q_prod[k]) s = s + {32'd0, q_prod[k]};
        e_acc = model_acc(s, 40);
        e_ovf = model_ovf(s, 40);

        chk("idle_prod_ready", ifa.prod_ready, 64'd0);
        ifa.start = 1'b1;
        ifa.len   = n[7:0];
        @(negedge clk);
        ifa.start = 1'b0;
        chk("busy_after_start", ifa.busy, 64'd1);
        if (n > 0) begin
            chk("accum_prod_ready", ifa.prod_ready, 64'd1);
            chk("accum_no_valid", ifa.acc_valid, 64'd0);
        end else begin
            chk("len0_prod_ready", ifa.prod_ready, 64'd0);
        end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                ifa.prod_valid = 1'b0;
                ifa.prod       = $urandom;
                ifa.start      = 1'($urandom_range(0, 1));
                ifa.len        = 8'($urandom);
                @(negedge clk);
                chk("gap_prod_ready", ifa.prod_ready, 64'd1);
                chk("gap_no_valid", ifa.acc_valid, 64'd0);
            end
            ifa.start      = 1'($urandom_range(0, 1));
            ifa.prod_valid = 1'b1;
            ifa.prod       = q_prod[i];
            @(negedge clk);
        end
        ifa.prod_valid = 1'b0;
        ifa.start      = 1'b0;
        chk("done_valid", ifa.acc_valid, 64'd1);
        chk("done_acc", ifa.acc, e_acc);
        chk("done_ovf", ifa.acc_ovf, e_ovf);
        chk("done_prod_ready", ifa.prod_ready, 64'd0);
        repeat (rdy_delay) begin
            ifa.acc_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", ifa.acc_valid, 64'd1);
            chk("hold_acc", ifa.acc, e_acc);
        end
        ifa.acc_ready = 1'b1;
        ifa.start     = start_on_exit;
        ifa.len       = 8'd3;
        @(negedge clk);
        ifa.acc_ready = 1'b0;
        ifa.start     = 1'b0;
        chk("exit_valid", ifa.acc_valid, 64'd0);
        chk("exit_busy", ifa.busy, 64'd0);
        chk("exit_acc_held", ifa.acc, e_acc);
        chk("exit_ovf_held", ifa.acc_ovf, e_ovf);
    endtask

    initial begin
        logic [63:0] s;
        logic [31:0] a;
        logic [31:0] b;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        ifa.start = 1'b0; ifa.len = 8'd0; ifa.prod = 32'd0; ifa.prod_valid = 1'b0; ifa.acc_ready = 1'b0;
        ifb.start = 1'b0; ifb.len = 8'd0; ifb.prod = 32'd0; ifb.prod_valid = 1'b0; ifb.acc_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_acc", ifa.acc, 64'd0);
        chk("rst_ovf", ifa.acc_ovf, 64'd0);
        chk("rst_valid", ifa.acc_valid, 64'd0);
        chk("rst_prod_ready", ifa.prod_ready, 64'd0);
        chk("rst_busy", ifa.busy, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a run, then a clean run.
        ifa.start = 1'b1; ifa.len = 8'd5;
        @(negedge clk);
        ifa.start = 1'b0;
        ifa.prod_valid = 1'b1; ifa.prod = 32'd1000;
        repeat (2) @(negedge clk);
        ifa.prod_valid = 1'b0;
        chk("mid_busy", ifa.busy, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_acc", ifa.acc, 64'd0);
        chk("arst_valid", ifa.acc_valid, 64'd0);
        chk("arst_busy", ifa.busy, 64'd0);
        chk("arst_prod_ready", ifa.prod_ready, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q_prod = '{32'd7, 32'd11, 32'd13};
        run_a(0, 0, 1'b0);

        // Basic: includes the largest 16x16 product.
        q_prod = '{32'd6, 32'd35, 32'd4294836225};
        run_a(0, 0, 1'b0);
        chk("basic_const", ifa.acc, 64'd4294836266);

        // Stalls on both streams; start in the exit cycle is ignored.
        q_prod = '{32'($urandom), 32'($urandom)};
        run_a(4, 5, 1'b1);

        // Zero-length accumulation.
        q_prod = {};
        run_a(0, 2, 1'b0);

        // Chained with a 16x16 multiplier model, gaps and stray starts.
        q_prod = {};
        for (int i = 0; i < 15; i++) begin
            a = 32'($urandom_range(0, 65535));
            b = 32'($urandom_range(0, 65535));
            q_prod.push_back(a * b);
        end
        run_a(3, 2, 1'b0);

        // Random lengths.
        for (int r = 0; r < 6; r++) begin
            q_prod = {};
            repeat ($urandom_range(1, 20)) q_prod.push_back(32'($urandom));
            run_a(2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Longest run the count field allows.
        q_prod = {};
        repeat (255) q_prod.push_back(32'hFFFF_FFFF);
        run_a(0, 1, 1'b0);

        // Carry on the 33-bit accumulator.
        s = 64'd3 * 64'd4294836225;
        ifb.start = 1'b1; ifb.len = 8'd3;
        @(negedge clk);
        ifb.start = 1'b0;
        ifb.prod_valid = 1'b1; ifb.prod = 32'd4294836225;
        repeat (3) @(negedge clk);
        ifb.prod_valid = 1'b0;
        chk("ovf_valid", ifb.acc_valid, 64'd1);
        chk("ovf_acc", ifb.acc, model_acc(s, 33));
        chk("ovf_flag", ifb.acc_ovf, model_ovf(s, 33));
`ifdef DADDA_ACC_SAT_EN
        chk("ovf_acc_const", ifb.acc, 64'd8589934591);
`else
        chk("ovf_acc_const", ifb.acc, 64'd4294574083);
`endif
        ifb.acc_ready = 1'b1;
        @(negedge clk);
        ifb.acc_ready = 1'b0;
        chk("ovf_exit_valid", ifb.acc_valid, 64'd0);
        chk("ovf_flag_held", ifb.acc_ovf, 64'd1);
        // A new start clears the sticky flag.
        ifb.start = 1'b1; ifb.len = 8'd1;
        @(negedge clk);
        ifb.start = 1'b0;
        chk("ovf_cleared", ifb.acc_ovf, 64'd0);
        ifb.prod_valid = 1'b1; ifb.prod = 32'd9;
        @(negedge clk);
        ifb.prod_valid = 1'b0;
        chk("b_small_acc", ifb.acc, 64'd9);
        ifb.acc_ready = 1'b1;
        @(negedge clk);
        ifb.acc_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dadda_mac_acc
